// File: rtl/fpga_bridge_pkg.sv
// rtl/fpga_bridge_pkg.sv - shared states and response codes for the AXI4-Lite to APB bridge
package fpga_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      WRESP,
      RRESP
   } bridge_state_e;

   localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
   localparam logic [31:0] TIMEOUT_RDATA   = 32'hDEAD_DEAD;

endpackage

// File: rtl/fpga_axil_apb_bridge_if.sv
// rtl/fpga_axil_apb_bridge_if.sv - AXI4-Lite and APB signal bundles used by the bridge
interface fpga_axil_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] s_axi_awaddr;
   logic              s_axi_awvalid;
   logic              s_axi_awready;
   logic [DATA_W-1:0] s_axi_wdata;
   logic [STRB_W-1:0] s_axi_wstrb;
   logic              s_axi_wvalid;
   logic              s_axi_wready;
   logic [1:0]        s_axi_bresp;
   logic              s_axi_bvalid;
   logic              s_axi_bready;
   logic [ADDR_W-1:0] s_axi_araddr;
   logic              s_axi_arvalid;
   logic              s_axi_arready;
   logic [DATA_W-1:0] s_axi_rdata;
   logic [1:0]        s_axi_rresp;
   logic              s_axi_rvalid;
   logic              s_axi_rready;

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

   modport master (
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );
endinterface

interface fpga_apb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int USER_W = 32
);
   logic [ADDR_W-1:0] PADDR;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic [2:0]        PPROT;
   logic [USER_W-1:0] PAUSER;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PPROT, PAUSER,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PPROT, PAUSER,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/fpga_axil_wr_capture.sv
// rtl/fpga_axil_wr_capture.sv - independent AW and W holding registers feeding the write arbiter
module fpga_axil_wr_capture #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic              wvalid,
   output logic              wready,
   input  logic              clear,
   output logic              aw_full,
   output logic              w_full,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic [STRB_W-1:0] strb
);

   logic aw_full_d;
   logic w_full_d;

   always_comb begin
      aw_full_d = clear ? 1'b0 : (aw_full | (awvalid & awready));
      w_full_d  = clear ? 1'b0 : (w_full | (wvalid & wready));
   end

   // Ready is registered as the complement of the next full flag so it stays low in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         awready <= 1'b0;
         wready  <= 1'b0;
         addr    <= '0;
         data    <= '0;
         strb    <= '0;
      end else begin
         aw_full <= aw_full_d;
         w_full  <= w_full_d;
         awready <= !aw_full_d;
         wready  <= !w_full_d;
         if (awvalid && awready) begin
            addr <= awaddr;
         end
         if (wvalid && wready) begin
            data <= wdata;
            strb <= wstrb;
         end
      end
   end

endmodule

// File: rtl/fpga_axil_apb_bridge.sv
// rtl/fpga_axil_apb_bridge.sv - single-outstanding AXI4-Lite slave to APB master with PREADY timeout
module fpga_axil_apb_bridge
   import fpga_bridge_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int USER_W      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic              core_clk,
   input  logic              cptra_rst_b,
   fpga_axil_if.slave        axi,
   fpga_apb_if.master        apb,
   input  logic [USER_W-1:0] pauser_i,
   output logic [15:0]       timeout_cnt_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(TIMEOUT_CYC);

   bridge_state_e     state;
   logic              favour_wr;
   logic              active;
   logic              is_read;
   logic [CNT_W-1:0]  wait_cnt;
   logic              aw_full;
   logic              w_full;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [STRB_W-1:0] wr_strb;
   logic              wr_elig;
   logic              rd_elig;
   logic              grant_wr;
   logic              grant_rd;

   fpga_axil_wr_capture #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .STRB_W (STRB_W)
   ) u_wr_capture (
      .clk     (core_clk),
      .rst_n   (cptra_rst_b),
      .awaddr  (axi.s_axi_awaddr),
      .awvalid (axi.s_axi_awvalid),
      .awready (axi.s_axi_awready),
      .wdata   (axi.s_axi_wdata),
      .wstrb   (axi.s_axi_wstrb),
      .wvalid  (axi.s_axi_wvalid),
      .wready  (axi.s_axi_wready),
      .clear   (grant_wr),
      .aw_full (aw_full),
      .w_full  (w_full),
      .addr    (wr_addr),
      .data    (wr_data),
      .strb    (wr_strb)
   );

   // Grants wait one cycle after reset so arready cannot rise while the bridge is held in reset.
   always_comb begin
      wr_elig  = active && (state == IDLE) && aw_full && w_full;
      rd_elig  = active && (state == IDLE) && axi.s_axi_arvalid;
      grant_wr = wr_elig && (!rd_elig || favour_wr);
      grant_rd = rd_elig && (!wr_elig || !favour_wr);
   end

   assign axi.s_axi_arready = grant_rd;
   assign apb.PPROT         = 3'b000;

   always_ff @(posedge core_clk or negedge cptra_rst_b) begin
      if (!cptra_rst_b) begin
         state            <= IDLE;
         favour_wr        <= 1'b1;
         active           <= 1'b0;
         is_read          <= 1'b0;
         wait_cnt         <= '0;
         apb.PADDR        <= '0;
         apb.PSEL         <= 1'b0;
         apb.PENABLE      <= 1'b0;
         apb.PWRITE       <= 1'b0;
         apb.PWDATA       <= '0;
         apb.PAUSER       <= '0;
         axi.s_axi_bvalid <= 1'b0;
         axi.s_axi_bresp  <= AXI_RESP_OKAY;
         axi.s_axi_rvalid <= 1'b0;
         axi.s_axi_rresp  <= AXI_RESP_OKAY;
         axi.s_axi_rdata  <= '0;
         timeout_cnt_o    <= '0;
      end else begin
         active <= 1'b1;
         unique case (state)
            IDLE: begin
               if (wr_elig && rd_elig) begin
                  favour_wr <= !favour_wr;
               end
               if (grant_wr) begin
                  // Partial strobes cannot be expressed on this APB port, so reject without a bus access.
                  if (wr_strb != '1) begin
                     axi.s_axi_bvalid <= 1'b1;
                     axi.s_axi_bresp  <= AXI_RESP_SLVERR;
                     state            <= WRESP;
                  end else begin
                     apb.PSEL   <= 1'b1;
                     apb.PADDR  <= wr_addr;
                     apb.PWRITE <= 1'b1;
                     apb.PWDATA <= wr_data;
                     apb.PAUSER <= pauser_i;
                     is_read    <= 1'b0;
                     state      <= SETUP;
                  end
               end else if (grant_rd) begin
                  apb.PSEL   <= 1'b1;
                  apb.PADDR  <= axi.s_axi_araddr;
                  apb.PWRITE <= 1'b0;
                  apb.PWDATA <= '0;
                  apb.PAUSER <= pauser_i;
                  is_read    <= 1'b1;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               apb.PENABLE <= 1'b1;
               wait_cnt    <= '0;
               state       <= ACCESS;
            end
            ACCESS: begin
               if (apb.PREADY) begin
                  apb.PSEL    <= 1'b0;
                  apb.PENABLE <= 1'b0;
                  if (is_read) begin
                     axi.s_axi_rdata  <= apb.PRDATA;
                     axi.s_axi_rresp  <= apb.PSLVERR ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                     axi.s_axi_rvalid <= 1'b1;
                     state            <= RRESP;
                  end else begin
                     axi.s_axi_bresp  <= apb.PSLVERR ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                     axi.s_axi_bvalid <= 1'b1;
                     state            <= WRESP;
                  end
               end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  apb.PSEL    <= 1'b0;
                  apb.PENABLE <= 1'b0;
                  if (timeout_cnt_o != 16'hFFFF) begin
                     timeout_cnt_o <= timeout_cnt_o + 16'd1;
                  end
                  if (is_read) begin
                     axi.s_axi_rdata  <= DATA_W'(TIMEOUT_RDATA);
                     axi.s_axi_rresp  <= AXI_RESP_DECERR;
                     axi.s_axi_rvalid <= 1'b1;
                     state            <= RRESP;
                  end else begin
                     axi.s_axi_bresp  <= AXI_RESP_DECERR;
                     axi.s_axi_bvalid <= 1'b1;
                     state            <= WRESP;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            WRESP: begin
               if (axi.s_axi_bready) begin
                  axi.s_axi_bvalid <= 1'b0;
                  state            <= IDLE;
               end
            end
            RRESP: begin
               if (axi.s_axi_rready) begin
                  axi.s_axi_rvalid <= 1'b0;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpga_axil_apb_bridge.sv
// tb/tb_fpga_axil_apb_bridge.sv - directed vector table plus corner sequences for the AXI4-Lite to APB bridge
module tb_fpga_axil_apb_bridge;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          wait_n;
      bit          slverr;
      logic [31:0] user;
      logic [1:0]  exp_resp;
      int          exp_setups;
      int          exp_lat;
   } vec_t;

   logic        clk;
   logic        rst_b;
   logic [31:0] pauser;
   logic [15:0] tcnt;

   fpga_axil_if #(.ADDR_W(32), .DATA_W(32)) axi ();
   fpga_apb_if #(.ADDR_W(32), .DATA_W(32), .USER_W(32)) apb ();

   fpga_axil_apb_bridge #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .USER_W      (32),
      .TIMEOUT_CYC (256)
   ) dut (
      .core_clk      (clk),
      .cptra_rst_b   (rst_b),
      .axi           (axi),
      .apb           (apb),
      .pauser_i      (pauser),
      .timeout_cnt_o (tcnt)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int b_cnt = 0, r_cnt = 0, b_cyc = 0, r_cyc = 0;
   logic [1:0]  last_bresp, last_rresp;
   logic [31:0] last_rdata;
   int setups = 0, acc_cycles = 0, wcnt = 0;
   logic [31:0] obs_addr, obs_wdata, obs_user;
   logic        obs_write;
   logic [2:0]  obs_prot;
   logic [1:0]  ord = 2'b00;
   int          cfg_wait = 0;
   bit          cfg_hang = 0, cfg_slv_wr = 0, cfg_slv_rd = 0;
   logic [31:0] cfg_rdata = 32'h0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Response monitor: with ready held high, valid seen at a falling edge completes on the next rising edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (axi.s_axi_bvalid && axi.s_axi_bready) begin
            b_cnt++;
            last_bresp = axi.s_axi_bresp;
            b_cyc = cyc;
         end
         if (axi.s_axi_rvalid && axi.s_axi_rready) begin
            r_cnt++;
            last_rresp = axi.s_axi_rresp;
            last_rdata = axi.s_axi_rdata;
            r_cyc = cyc;
         end
      end
   end

   // APB slave model with configurable wait states, error and hang.
   initial begin
      apb.PREADY  = 1'b0;
      apb.PRDATA  = 32'h0;
      apb.PSLVERR = 1'b0;
      forever begin
         @(negedge clk);
         if (apb.PSEL && !apb.PENABLE) begin
            setups++;
            obs_addr  = apb.PADDR;
            obs_wdata = apb.PWDATA;
            obs_write = apb.PWRITE;
            obs_user  = apb.PAUSER;
            obs_prot  = apb.PPROT;
            ord       = {ord[0], apb.PWRITE};
            wcnt      = 0;
         end
         if (apb.PSEL && apb.PENABLE) begin
            acc_cycles++;
            if (!cfg_hang && wcnt == cfg_wait) begin
               apb.PREADY  = 1'b1;
               apb.PRDATA  = cfg_rdata;
               apb.PSLVERR = apb.PWRITE ? cfg_slv_wr : cfg_slv_rd;
            end else begin
               apb.PREADY  = 1'b0;
               apb.PRDATA  = 32'h0BAD_0000;
               apb.PSLVERR = 1'b1;
               wcnt++;
            end
         end else begin
            apb.PREADY  = 1'b0;
            apb.PRDATA  = 32'h0BAD_0000;
            apb.PSLVERR = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit aw_hs, w_hs;
      axi.s_axi_awaddr  = a;
      axi.s_axi_awvalid = 1'b1;
      axi.s_axi_wdata   = d;
      axi.s_axi_wstrb   = s;
      axi.s_axi_wvalid  = 1'b1;
      for (int k = 0; k < 50; k++) begin
         #1;
         aw_hs = axi.s_axi_awvalid && axi.s_axi_awready;
         w_hs  = axi.s_axi_wvalid && axi.s_axi_wready;
         @(negedge clk);
         if (aw_hs) axi.s_axi_awvalid = 1'b0;
         if (w_hs) axi.s_axi_wvalid = 1'b0;
         if (!axi.s_axi_awvalid && !axi.s_axi_wvalid) return;
      end
      fail_now("aw_w_accept");
      axi.s_axi_awvalid = 1'b0;
      axi.s_axi_wvalid  = 1'b0;
   endtask

   task automatic ar_req(input logic [31:0] a, output int hs);
      axi.s_axi_araddr  = a;
      axi.s_axi_arvalid = 1'b1;
      hs = -1;
      for (int k = 0; k < 100; k++) begin
         #1;
         if (axi.s_axi_arready) begin
            hs = cyc;
            @(negedge clk);
            axi.s_axi_arvalid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      fail_now("ar_accept");
      axi.s_axi_arvalid = 1'b0;
   endtask

   task automatic wait_resp(input bit is_b, input int base, input int limit, input string name);
      for (int k = 0; k < limit; k++) begin
         if ((is_b ? b_cnt : r_cnt) > base) return;
         @(negedge clk);
         #1;
      end
      fail_now(name);
   endtask

   vec_t tbl[8];
   int   s0, b0, r0, a0, hs;
   logic [31:0] held;

   initial begin
      tbl[0] = '{1'b1, 32'h0003_0030, 32'h1234_5678, 4'hF, 0, 1'b0, 32'h0000_0001, 2'b00, 1, 0};
      tbl[1] = '{1'b0, 32'h0003_0000, 32'hCAFE_F00D, 4'h0, 3, 1'b0, 32'h0000_0002, 2'b00, 1, 6};
      tbl[2] = '{1'b1, 32'h0003_0004, 32'hDEAD_BEEF, 4'h3, 0, 1'b0, 32'h0000_0003, 2'b10, 0, 0};
      tbl[3] = '{1'b1, 32'h0003_0007, 32'hA5A5_A5A5, 4'hF, 1, 1'b1, 32'h8000_0004, 2'b10, 1, 0};
      tbl[4] = '{1'b0, 32'h0003_0013, 32'h1122_3344, 4'h0, 0, 1'b1, 32'h0000_0005, 2'b10, 1, 3};
      tbl[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 2, 1'b0, 32'hFFFF_FFFF, 2'b00, 1, 5};
      tbl[6] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h0000_0007, 2'b00, 1, 0};
      tbl[7] = '{1'b1, 32'h0003_0008, 32'h0000_0001, 4'h0, 0, 1'b0, 32'h0000_0008, 2'b10, 0, 0};

      rst_b = 1'b0;
      pauser = 32'hA5A5_0001;
      axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0;
      axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0; axi.s_axi_wvalid = 1'b0;
      axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0;
      axi.s_axi_bready = 1'b1; axi.s_axi_rready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ctrl", {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready, axi.s_axi_bvalid,
                       axi.s_axi_rvalid, apb.PSEL, apb.PENABLE, apb.PWRITE}, 8'h00);
      chk("rst_paddr_pwdata", {apb.PADDR, apb.PWDATA}, 64'h0);
      chk("rst_pauser", apb.PAUSER, 32'h0);
      chk("rst_rdata_resp", {axi.s_axi_rdata, axi.s_axi_rresp, axi.s_axi_bresp}, 36'h0);
      chk("rst_tcnt", tcnt, 16'h0);
      @(negedge clk);
      rst_b = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("post_rst_ready", {axi.s_axi_awready, axi.s_axi_wready}, 2'b11);

      for (int i = 0; i < 8; i++) begin
         cfg_wait   = tbl[i].wait_n;
         cfg_rdata  = tbl[i].data;
         cfg_slv_wr = tbl[i].slverr;
         cfg_slv_rd = tbl[i].slverr;
         pauser     = tbl[i].user;
         s0 = setups; b0 = b_cnt; r0 = r_cnt;
         if (tbl[i].wr) begin
            wr_req(tbl[i].addr, tbl[i].data, tbl[i].strb);
            wait_resp(1'b1, b0, 100, $sformatf("v%0d_bwait", i));
            chk($sformatf("v%0d_bresp", i), last_bresp, tbl[i].exp_resp);
         end else begin
            ar_req(tbl[i].addr, hs);
            wait_resp(1'b0, r0, 100, $sformatf("v%0d_rwait", i));
            chk($sformatf("v%0d_rresp", i), last_rresp, tbl[i].exp_resp);
            chk($sformatf("v%0d_rdata", i), last_rdata, tbl[i].data);
            chk($sformatf("v%0d_latency", i), r_cyc - hs, tbl[i].exp_lat);
         end
         chk($sformatf("v%0d_setups", i), setups - s0, tbl[i].exp_setups);
         if (tbl[i].exp_setups == 1) begin
            chk($sformatf("v%0d_paddr", i), obs_addr, tbl[i].addr);
            chk($sformatf("v%0d_pwrite", i), obs_write, tbl[i].wr);
            chk($sformatf("v%0d_pwdata", i), obs_wdata, tbl[i].wr ? tbl[i].data : 32'h0);
            chk($sformatf("v%0d_pauser", i), obs_user, tbl[i].user);
            chk($sformatf("v%0d_pprot", i), obs_prot, 3'b000);
         end
      end

      // W leads AW by four cycles with a partial strobe: no APB access, SLVERR.
      s0 = setups; b0 = b_cnt;
      axi.s_axi_wdata = 32'h0000_5555; axi.s_axi_wstrb = 4'h3; axi.s_axi_wvalid = 1'b1;
      #1;
      chk("wfirst_wready", axi.s_axi_wready, 1'b1);
      @(negedge clk);
      axi.s_axi_wvalid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("wfirst_held", {axi.s_axi_wready, axi.s_axi_awready}, 2'b01);
      axi.s_axi_awaddr = 32'h0003_0010; axi.s_axi_awvalid = 1'b1;
      @(negedge clk);
      axi.s_axi_awvalid = 1'b0;
      wait_resp(1'b1, b0, 50, "wfirst_bwait");
      chk("wfirst_bresp", last_bresp, 2'b10);
      chk("wfirst_no_psel", setups - s0, 0);

      // Hung slave: read times out, response held while rready is low.
      cfg_hang = 1'b1;
      axi.s_axi_rready = 1'b0;
      a0 = acc_cycles;
      ar_req(32'h0003_0020, hs);
      for (int k = 0; k < 400; k++) begin
         if (axi.s_axi_rvalid) break;
         @(negedge clk);
         #1;
      end
      chk("to_rvalid", axi.s_axi_rvalid, 1'b1);
      chk("to_access_cycles", acc_cycles - a0, 256);
      chk("to_psel_low", {apb.PSEL, apb.PENABLE}, 2'b00);
      chk("to_rresp", axi.s_axi_rresp, 2'b11);
      chk("to_rdata", axi.s_axi_rdata, 32'hDEAD_DEAD);
      chk("to_count", tcnt, 16'd1);
      held = axi.s_axi_rdata;
      repeat (3) @(negedge clk);
      #1;
      chk("to_hold", {axi.s_axi_rvalid, axi.s_axi_rresp, axi.s_axi_rdata}, {1'b1, 2'b11, held});
      axi.s_axi_rready = 1'b1;
      @(negedge clk);
      #1;
      chk("to_consumed", axi.s_axi_rvalid, 1'b0);
      cfg_hang = 1'b0;

      // Two collisions: write wins the first, read wins the second.
      cfg_wait = 0; cfg_slv_wr = 1'b1; cfg_slv_rd = 1'b0; cfg_rdata = 32'h55AA_55AA;
      for (int c = 0; c < 2; c++) begin
         b0 = b_cnt; r0 = r_cnt;
         wr_req(32'h0003_0040, 32'h0000_0040 + c, 4'hF);
         ar_req(32'h0003_0044, hs);
         wait_resp(1'b1, b0, 100, $sformatf("col%0d_bwait", c));
         wait_resp(1'b0, r0, 100, $sformatf("col%0d_rwait", c));
         chk($sformatf("col%0d_order", c), ord, (c == 0) ? 2'b10 : 2'b01);
         chk($sformatf("col%0d_b_before_r", c), b_cyc < r_cyc, c == 0);
         chk($sformatf("col%0d_bresp", c), last_bresp, 2'b10);
         chk($sformatf("col%0d_rresp_rdata", c), {last_rresp, last_rdata}, {2'b00, 32'h55AA_55AA});
      end
      cfg_slv_wr = 1'b0;

      // Reset during ACCESS drops the transfer with no response.
      cfg_hang = 1'b1;
      b0 = b_cnt; r0 = r_cnt;
      ar_req(32'h0003_0050, hs);
      for (int k = 0; k < 20; k++) begin
         #1;
         if (apb.PENABLE) break;
         @(negedge clk);
      end
      chk("mid_rst_in_access", apb.PENABLE, 1'b1);
      rst_b = 1'b0;
      #1;
      chk("mid_rst_outputs", {apb.PSEL, apb.PENABLE, axi.s_axi_bvalid, axi.s_axi_rvalid}, 4'b0000);
      chk("mid_rst_tcnt", tcnt, 16'h0);
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      cfg_hang = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("mid_rst_no_resp", {b_cnt - b0, r_cnt - r0}, 64'h0);
      cfg_wait = 1; cfg_rdata = 32'h0F0F_1234;
      r0 = r_cnt;
      ar_req(32'h0003_0060, hs);
      wait_resp(1'b0, r0, 100, "after_rst_rwait");
      chk("after_rst_read", {last_rresp, last_rdata}, {2'b00, 32'h0F0F_1234});
      chk("after_rst_latency", r_cyc - hs, 4);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpga_axil_apb_bridge.md
Name: fpga_axil_apb_bridge

Overview:
AXI4-Lite slave to APB master bridge in the FPGA build, directly upstream of the Caliptra wrapper's SoC APB port (PADDR/PSEL/PENABLE/PWRITE/PWDATA/PAUSER in; PRDATA/PREADY/PSLVERR out).
Converts single-outstanding AXI4-Lite reads and writes from the Zynq PS into APB transfers, and drives PAUSER from a sideband input.
Adds a PREADY timeout so a hung APB slave cannot stall the PS bus.

Parameters:
ADDR_W, 32, AXI and APB address width (matches CALIPTRA_APB_ADDR_WIDTH)
DATA_W, 32, data width; fixed at 32, STRB_W = DATA_W/8
USER_W, 32, PAUSER width (matches CALIPTRA_APB_USER_WIDTH)
TIMEOUT_CYC, 256, ACCESS-phase cycles without PREADY before abort; must be >= 2

Ports:
core_clk  in  1  bridge clock, same clock as the APB slave
cptra_rst_b  in  1  asynchronous active-low reset
s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  AXI write address channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/STRB_W/1/1  AXI write data channel
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  AXI write response channel
s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  AXI read address channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  AXI read data channel
pauser_i  in  USER_W  PAUSER value; sampled at SETUP entry
PADDR/PSEL/PENABLE/PWRITE/PWDATA/PPROT/PAUSER  out  ADDR_W/1/1/1/DATA_W/3/USER_W  APB master request
PRDATA/PREADY/PSLVERR  in  DATA_W/1/1  APB completion
timeout_cnt_o  out  16  saturating count of timed-out transfers (debug)

Behaviour:
- Reset: all ready, valid, PSEL, PENABLE, PWRITE and timeout_cnt_o are 0; all data, address, resp and PAUSER outputs are 0; FSM in IDLE; arbiter favours write.
- AW and W are captured independently into holding registers. awready = aw_empty; wready = w_empty. Each holding register clears when its write is issued.
- FSM states: IDLE, SETUP, ACCESS, WRESP, RRESP.
- IDLE: write is eligible when both AW and W are held. Read is eligible on arvalid; arready pulses only in the cycle the read is granted.
  - One eligible: grant it.
  - Both eligible: grant the favoured one, then flip the favour (round-robin).
  - Granted write with wstrb != all-ones: no APB access; go to WRESP with bresp=2'b10 (SLVERR).
  - Any other grant: go to SETUP.
- SETUP, one cycle: PSEL=1, PENABLE=0. PADDR/PWRITE/PWDATA/PAUSER are registered and held stable until the transfer ends. PPROT=3'b000. PWDATA=0 for reads.
- ACCESS: PSEL=1, PENABLE=1. On PREADY:
  - Latch PRDATA for reads.
  - resp = PSLVERR ? 2'b10 : 2'b00.
  - Deassert PSEL/PENABLE in the next cycle; go to WRESP or RRESP.
- Timeout: if PREADY stays low for TIMEOUT_CYC ACCESS cycles, abort. Drop PSEL/PENABLE, resp=2'b11 (DECERR), rdata=32'hDEAD_DEAD, timeout_cnt_o increments (saturates at 16'hFFFF).
- WRESP/RRESP: assert bvalid/rvalid and hold resp/data stable until the matching ready; then return to IDLE.
- Back-to-back issue: the next grant happens in IDLE one cycle after the response handshake.
- Minimum latency from AR handshake to rvalid is 3 cycles with zero-wait PREADY (SETUP, ACCESS, RRESP).
- Address passes through unmodified, including the low bits.
- Reset mid-transfer: immediate asynchronous return to the reset state; the in-flight transfer is dropped and no response is issued.

Decomposition:
- fpga_bridge_pkg holds:
  - bridge_state_e enum (IDLE, SETUP, ACCESS, WRESP, RRESP)
  - AXI_RESP_OKAY/SLVERR/DECERR constants
  - TIMEOUT_RDATA = 32'hDEAD_DEAD
- One sub-module, fpga_axil_wr_capture: the AW/W independent holding registers with the ready/clear logic.

Test Plan:
- Write awaddr=0x30030, wdata=0x1234_5678, wstrb=4'hF, PREADY zero-wait -> one SETUP+ACCESS with PADDR=0x30030, PWDATA=0x12345678, PWRITE=1; then bresp=2'b00.
- Read araddr=0x30000, PRDATA=0xCAFE_F00D after 3 wait states -> rdata=0xCAFEF00D, rresp=2'b00, rvalid 6 cycles after the AR handshake.
- W presented 4 cycles before AW, wstrb=4'h3 -> APB PSEL never asserted; bresp=2'b10.
- PREADY tied low, TIMEOUT_CYC=256 read -> PSEL drops after 256 ACCESS cycles; rresp=2'b11, rdata=0xDEADDEAD, timeout_cnt_o=1.
- Read and write eligible in the same cycle, twice in a row, PSLVERR=1 on the write -> write first with bresp=2'b10, then the read; on the second collision the read goes first.
- Assert cptra_rst_b=0 during ACCESS -> PSEL/PENABLE/bvalid/rvalid are 0 in the same cycle; after release a new read completes normally.
